// File: rtl/biquad_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : biquad_stream_adapter
// Brief    : valid/ready wrapper that paces samples into a strobed biquad
//            filter and buffers its results under credit-based flow control.
// Revision : 1.0 - initial release
// ============================================================================
module biquad_stream_adapter #(
  parameter int WIDTH_D       = 18,
  parameter int IN_DEPTH      = 4,
  parameter int OUT_DEPTH     = 4,
  parameter int STROBE_PERIOD = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [WIDTH_D-1:0]                 s_data,
  output logic                               filt_strobe,
  output logic [WIDTH_D-1:0]                 filt_data,
  input  logic                               filt_out_strobe,
  input  logic [WIDTH_D-1:0]                 filt_out_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [WIDTH_D-1:0]                 m_data,
  output logic [$clog2(OUT_DEPTH+1)-1:0]     in_flight,
  output logic                               err
);

  localparam int c_in_aw  = $clog2(IN_DEPTH);
  localparam int c_in_cw  = $clog2(IN_DEPTH + 1);
  localparam int c_out_aw = $clog2(OUT_DEPTH);
  localparam int c_out_cw = $clog2(OUT_DEPTH + 1);
  localparam int c_pace_w = $clog2(STROBE_PERIOD + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_PACE  = 2'd2
  } state_t;

  // ------------------------------------------------------------------ input FIFO
  logic [WIDTH_D-1:0]  r_in_mem [IN_DEPTH];
  logic [c_in_aw-1:0]  r_in_wr;
  logic [c_in_aw-1:0]  r_in_rd;
  logic [c_in_cw-1:0]  r_in_cnt;
  logic [c_in_cw-1:0]  w_in_cnt_nxt;
  logic                r_s_ready;
  logic                w_in_push;
  logic                w_in_pop;

  assign w_in_push = s_valid && r_s_ready;

  always_comb begin
    w_in_cnt_nxt = r_in_cnt;
    if (w_in_push && !w_in_pop) begin
      w_in_cnt_nxt = r_in_cnt + 1'b1;
    end else if (!w_in_push && w_in_pop) begin
      w_in_cnt_nxt = r_in_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IN_DEPTH; i++) begin
        r_in_mem[i] <= '0;
      end
      r_in_wr   <= '0;
      r_in_rd   <= '0;
      r_in_cnt  <= '0;
      r_s_ready <= 1'b1;
    end else begin
      if (w_in_push) begin
        r_in_mem[r_in_wr] <= s_data;
        r_in_wr           <= r_in_wr + 1'b1;
      end
      if (w_in_pop) begin
        r_in_rd <= r_in_rd + 1'b1;
      end
      r_in_cnt  <= w_in_cnt_nxt;
      r_s_ready <= (w_in_cnt_nxt != c_in_cw'(IN_DEPTH));
    end
  end

  // ------------------------------------------------------------------ credits
  logic [c_out_cw-1:0] r_in_flight;
  logic [c_out_cw-1:0] r_out_cnt;
  logic [c_out_cw:0]   w_credit_sum;
  logic                w_credit_ok;

  assign w_credit_sum = {1'b0, r_in_flight} + {1'b0, r_out_cnt};
  assign w_credit_ok  = (w_credit_sum < (c_out_cw + 1)'(OUT_DEPTH));

  // ------------------------------------------------------------------ issue FSM
  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_pace_w-1:0] r_pace;
  logic [c_pace_w-1:0] w_pace_nxt;
  logic                r_filt_strobe;
  logic [WIDTH_D-1:0]  r_filt_data;

  // The IDLE decision cycle is the last cycle of the pacing window, so PACE
  // hands over two counts early to keep strobes exactly STROBE_PERIOD apart.
  always_comb begin
    w_state_nxt = r_state;
    w_pace_nxt  = r_pace;
    case (r_state)
      ST_IDLE: begin
        if ((r_in_cnt != '0) && w_credit_ok) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_pace_nxt  = c_pace_w'(STROBE_PERIOD - 1);
        w_state_nxt = (STROBE_PERIOD > 2) ? ST_PACE : ST_IDLE;
      end
      ST_PACE: begin
        w_pace_nxt = r_pace - 1'b1;
        if (r_pace <= c_pace_w'(2)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The head is popped on the edge entering ISSUE so filt_data is already
  // valid while the strobe is high.
  assign w_in_pop = (r_state == ST_IDLE) && (w_state_nxt == ST_ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pace        <= '0;
      r_filt_strobe <= 1'b0;
      r_filt_data   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pace        <= w_pace_nxt;
      r_filt_strobe <= w_in_pop;
      if (w_in_pop) begin
        r_filt_data <= r_in_mem[r_in_rd];
      end
    end
  end

  // ------------------------------------------------------------------ output FIFO
  logic [WIDTH_D-1:0]  r_out_mem [OUT_DEPTH];
  logic [c_out_aw-1:0] r_out_wr;
  logic [c_out_aw-1:0] r_out_rd;
  logic [c_out_cw-1:0] w_out_cnt_nxt;
  logic [c_out_cw-1:0] w_in_flight_nxt;
  logic                r_m_valid;
  logic                r_err;
  logic                w_out_full;
  logic                w_out_pop;
  logic                w_out_push;
  logic                w_if_dec;
  logic                w_err_evt;

  assign w_out_full = (r_out_cnt == c_out_cw'(OUT_DEPTH));
  assign w_out_pop  = r_m_valid && m_ready;
  assign w_out_push = filt_out_strobe && (!w_out_full || w_out_pop);
  assign w_if_dec   = filt_out_strobe && (r_in_flight != '0);
  assign w_err_evt  = filt_out_strobe &&
                      ((r_in_flight == '0) || (w_out_full && !w_out_pop));

  always_comb begin
    w_out_cnt_nxt = r_out_cnt;
    if (w_out_push && !w_out_pop) begin
      w_out_cnt_nxt = r_out_cnt + 1'b1;
    end else if (!w_out_push && w_out_pop) begin
      w_out_cnt_nxt = r_out_cnt - 1'b1;
    end
    w_in_flight_nxt = r_in_flight;
    if (r_filt_strobe && !w_if_dec) begin
      w_in_flight_nxt = r_in_flight + 1'b1;
    end else if (!r_filt_strobe && w_if_dec) begin
      w_in_flight_nxt = r_in_flight - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        r_out_mem[i] <= '0;
      end
      r_out_wr    <= '0;
      r_out_rd    <= '0;
      r_out_cnt   <= '0;
      r_m_valid   <= 1'b0;
      r_in_flight <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_out_push) begin
        r_out_mem[r_out_wr] <= filt_out_data;
        r_out_wr            <= r_out_wr + 1'b1;
      end
      if (w_out_pop) begin
        r_out_rd <= r_out_rd + 1'b1;
      end
      r_out_cnt   <= w_out_cnt_nxt;
      r_m_valid   <= (w_out_cnt_nxt != '0);
      r_in_flight <= w_in_flight_nxt;
      if (w_err_evt) begin
        r_err <= 1'b1;
      end
    end
  end

  assign s_ready     = r_s_ready;
  assign filt_strobe = r_filt_strobe;
  assign filt_data   = r_filt_data;
  assign m_valid     = r_m_valid;
  assign m_data      = r_out_mem[r_out_rd];
  assign in_flight   = r_in_flight;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_biquad_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_biquad_stream_adapter
// Brief    : scoreboard bench with a simple filter model for the adapter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_biquad_stream_adapter;

  localparam int W   = 18;
  localparam int LAT = 9;
  localparam int PER = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         filt_strobe;
  logic [W-1:0] filt_data;
  logic         filt_out_strobe;
  logic [W-1:0] filt_out_data;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic [2:0]   in_flight;
  logic         err;

  always #5 clk = ~clk;

  biquad_stream_adapter #(
    .WIDTH_D(W), .IN_DEPTH(4), .OUT_DEPTH(4), .STROBE_PERIOD(PER)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .filt_strobe(filt_strobe), .filt_data(filt_data),
    .filt_out_strobe(filt_out_strobe), .filt_out_data(filt_out_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .in_flight(in_flight), .err(err)
  );

  logic [W-1:0] src[$];
  logic [W-1:0] sb[$];
  logic [W-1:0] pend_d[$];
  int           pend_t[$];
  int           strobe_cyc[$];
  int           cyc = 0;
  int           last_acc = 0;
  int           n_acc = 0;
  int           n_del = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  bit           auto_ret = 1'b0;

  // Filter model transfer function: any bijection distinguishes results.
  function automatic logic [W-1:0] fmodel(input logic [W-1:0] x);
    return x + 18'h00333;
  endfunction

  // One clock: judge handshakes from pre-edge values, then drive next inputs.
  task automatic step();
    logic         s_fire, m_fire, stb;
    logic [W-1:0] sd, md, fd, want;
    s_fire = s_valid && s_ready;
    m_fire = m_valid && m_ready;
    stb    = filt_strobe;
    sd     = s_data;
    md     = m_data;
    fd     = filt_data;
    @(posedge clk);
    #1;
    cyc++;
    if (s_fire) begin
      sb.push_back(fmodel(sd));
      if (src.size() > 0) void'(src.pop_front());
      n_acc++;
      last_acc = cyc;
    end
    if (stb) begin
      pend_d.push_back(fd);
      pend_t.push_back(cyc + LAT - 1);
      strobe_cyc.push_back(cyc);
    end
    if (m_fire) begin
      n_checks++;
      n_del++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL m_data_order: got %h, required nothing (no result pending)", md);
      end else begin
        want = sb.pop_front();
        if (md !== want) begin
          n_fail++;
          $display("FAIL m_data_order: got %h, required %h", md, want);
        end
      end
    end
    filt_out_strobe = 1'b0;
    filt_out_data   = '0;
    if (auto_ret && pend_t.size() > 0 && cyc >= pend_t[0]) begin
      filt_out_strobe = 1'b1;
      filt_out_data   = fmodel(pend_d.pop_front());
      void'(pend_t.pop_front());
    end
    s_valid = (src.size() > 0);
    s_data  = (src.size() > 0) ? src[0] : '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    filt_out_strobe = 1'b0; filt_out_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({s_ready, filt_strobe, filt_data, m_valid, m_data, in_flight, err} !==
        {1'b1, 1'b0, 18'h0, 1'b0, 18'h0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got sr=%b fs=%b fd=%h mv=%b md=%h if=%0d err=%b, required 1 0 0 0 0 0 0",
               s_ready, filt_strobe, filt_data, m_valid, m_data, in_flight, err);
    end
    rst_n = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({s_ready, filt_strobe, m_valid, err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got sr=%b fs=%b mv=%b err=%b, required 1 0 0 0",
               s_ready, filt_strobe, m_valid, err);
    end
  endtask

  task automatic test_single();
    auto_ret = 1'b0;
    strobe_cyc.delete();
    src.push_back(18'h00123);
    for (int i = 0; i < 20 && strobe_cyc.size() == 0; i++) step();
    n_checks++;
    if (strobe_cyc.size() == 0) begin
      n_fail++;
      $display("FAIL single_strobe_seen: got no strobe, required one");
      return;
    end
    n_checks++;
    if (strobe_cyc[0] - last_acc != 2) begin
      n_fail++;
      $display("FAIL single_latency: got %0d cycles, required 2", strobe_cyc[0] - last_acc);
    end
    n_checks++;
    if (pend_d[0] !== 18'h00123) begin
      n_fail++;
      $display("FAIL single_filt_data: got %h, required 00123", pend_d[0]);
    end
    n_checks++;
    if (in_flight !== 3'd1) begin
      n_fail++;
      $display("FAIL single_in_flight: got %0d, required 1", in_flight);
    end
    repeat (8) step();
    n_checks++;
    if (strobe_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL single_strobe_count: got %0d, required 1", strobe_cyc.size());
    end
    void'(pend_d.pop_front());
    void'(pend_t.pop_front());
    filt_out_strobe = 1'b1;
    filt_out_data   = 18'h00456;
    step();
    n_checks++;
    if ({m_valid, m_data, in_flight} !== {1'b1, 18'h00456, 3'd0}) begin
      n_fail++;
      $display("FAIL single_result: got mv=%b md=%h if=%0d, required 1 00456 0",
               m_valid, m_data, in_flight);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drained: got m_valid=%b, required 0", m_valid);
    end
  endtask

  task automatic test_back_to_back();
    int first_low = -1;
    auto_ret = 1'b1;
    m_ready  = 1'b1;
    strobe_cyc.delete();
    n_acc = 0;
    n_del = 0;
    for (int i = 0; i < 8; i++) src.push_back(18'(i * 18'h05A3B) ^ 18'h20001);
    for (int i = 0; i < 300 && n_del < 8; i++) begin
      step();
      if (!s_ready && first_low < 0) first_low = n_acc;
    end
    n_checks++;
    if (n_del != 8) begin
      n_fail++;
      $display("FAIL burst_delivered: got %0d, required 8", n_del);
    end
    n_checks++;
    if (first_low != 5) begin
      n_fail++;
      $display("FAIL burst_s_ready_drop: got drop after %0d accepted, required 5", first_low);
    end
    for (int i = 1; i < strobe_cyc.size(); i++) begin
      n_checks++;
      if (strobe_cyc[i] - strobe_cyc[i-1] != PER) begin
        n_fail++;
        $display("FAIL burst_strobe_gap%0d: got %0d, required %0d", i,
                 strobe_cyc[i] - strobe_cyc[i-1], PER);
      end
    end
    n_checks++;
    if (err !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL burst_clean: got err=%b left=%0d, required err=0 left=0", err, sb.size());
    end
  endtask

  task automatic test_backpressure();
    auto_ret = 1'b1;
    m_ready  = 1'b0;
    strobe_cyc.delete();
    n_del = 0;
    for (int i = 0; i < 10; i++) src.push_back(18'(18'h3FF00 - i * 18'h00777));
    repeat (80) step();
    n_checks++;
    if (strobe_cyc.size() != 4 || in_flight !== 3'd0 || m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_credit_stall: got strobes=%0d if=%0d mv=%b, required 4 0 1",
               strobe_cyc.size(), in_flight, m_valid);
    end
    repeat (20) step();
    n_checks++;
    if (strobe_cyc.size() != 4) begin
      n_fail++;
      $display("FAIL bp_no_extra_strobe: got %0d, required 4", strobe_cyc.size());
    end
    m_ready = 1'b1;
    for (int i = 0; i < 400 && n_del < 10; i++) step();
    n_checks++;
    if (n_del != 10 || strobe_cyc.size() != 10 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got del=%0d strobes=%0d err=%b, required 10 10 0",
               n_del, strobe_cyc.size(), err);
    end
  endtask

  task automatic test_simultaneous();
    auto_ret = 1'b0;
    m_ready  = 1'b0;
    strobe_cyc.delete();
    n_del = 0;
    for (int i = 0; i < 4; i++) src.push_back(18'(18'h01010 * (i + 3)));
    repeat (40) step();
    n_checks++;
    if (strobe_cyc.size() != 4 || in_flight !== 3'd4) begin
      n_fail++;
      $display("FAIL sim_setup: got strobes=%0d if=%0d, required 4 4", strobe_cyc.size(), in_flight);
      return;
    end
    for (int k = 0; k < 3; k++) begin
      filt_out_strobe = 1'b1;
      filt_out_data   = fmodel(pend_d.pop_front());
      void'(pend_t.pop_front());
      step();
    end
    filt_out_strobe = 1'b1;
    filt_out_data   = fmodel(pend_d.pop_front());
    void'(pend_t.pop_front());
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    n_checks++;
    if ({in_flight, m_valid, err} !== {3'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL sim_push_pop: got if=%0d mv=%b err=%b, required 0 1 0", in_flight, m_valid, err);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 20 && n_del < 4; i++) step();
    m_ready = 1'b0;
    n_checks++;
    if (n_del != 4 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL sim_no_drop: got del=%0d left=%0d, required 4 0", n_del, sb.size());
    end
  endtask

  task automatic test_error();
    auto_ret = 1'b1;
    m_ready  = 1'b0;
    n_del = 0;
    for (int i = 0; i < 4; i++) src.push_back(18'(18'h2A000 + i));
    repeat (60) step();
    n_checks++;
    if (err !== 1'b0 || in_flight !== 3'd0 || m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL err_setup: got err=%b if=%0d mv=%b, required 0 0 1", err, in_flight, m_valid);
    end
    filt_out_strobe = 1'b1;
    filt_out_data   = 18'h15A5A;
    sb.push_back(18'h15A5A);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_unsolicited: got %b, required 1", err);
    end
    repeat (5) step();
    filt_out_strobe = 1'b1;
    filt_out_data   = 18'h0BEEF;
    step();
    repeat (3) step();
    n_checks++;
    if (err !== 1'b1 || in_flight !== 3'd0) begin
      n_fail++;
      $display("FAIL err_sticky: got err=%b if=%0d, required 1 0", err, in_flight);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 30 && m_valid; i++) step();
    m_ready = 1'b0;
    repeat (2) step();
    n_checks++;
    if (n_del != 5 || m_valid !== 1'b0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_drain: got del=%0d mv=%b err=%b, required 5 0 1", n_del, m_valid, err);
    end
  endtask

  task automatic test_reset_mid();
    auto_ret = 1'b0;
    m_ready  = 1'b0;
    strobe_cyc.delete();
    for (int i = 0; i < 5; i++) src.push_back(18'(18'h00F0F + i * 18'h01000));
    for (int i = 0; i < 40 && strobe_cyc.size() < 2; i++) step();
    step();
    n_checks++;
    if (in_flight !== 3'd2 || s_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_setup: got if=%0d s_valid=%b, required 2 0", in_flight, s_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_ready, filt_strobe, filt_data, m_valid, m_data, in_flight, err} !==
        {1'b1, 1'b0, 18'h0, 1'b0, 18'h0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_async: got sr=%b fs=%b fd=%h mv=%b md=%h if=%0d err=%b, required 1 0 0 0 0 0 0",
               s_ready, filt_strobe, filt_data, m_valid, m_data, in_flight, err);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    src.delete();
    sb.delete();
    pend_d.delete();
    pend_t.delete();
    strobe_cyc.delete();
    repeat (20) step();
    n_checks++;
    if (strobe_cyc.size() != 0 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_quiet: got strobes=%0d sr=%b mv=%b, required 0 1 0",
               strobe_cyc.size(), s_ready, m_valid);
    end
    auto_ret = 1'b1;
    m_ready  = 1'b1;
    n_del = 0;
    src.push_back(18'h1CAFE);
    for (int i = 0; i < 40 && n_del < 1; i++) step();
    n_checks++;
    if (n_del != 1) begin
      n_fail++;
      $display("FAIL rst_recover: got del=%0d, required 1", n_del);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_simultaneous();
    test_error();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
